// File: rtl/hdmi_packet_picker.sv
// Picks one data-island packet per slot (ACR, audio sample, AVI, Audio InfoFrame, Null) and
// registers its header/subpackets for the ECC stage. Define HDMI_AUDIO_EN for audio support.
module hdmi_packet_picker #(
  parameter int unsigned VIC              = 1,
  parameter int unsigned AUDIO_N          = 6144,
  parameter int unsigned AUDIO_CTS        = 27000,
  parameter int unsigned AUDIO_FIFO_DEPTH = 4
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             packet_enable,
  input  logic             video_field_end,
  input  logic             acr_tick,
  input  logic [47:0]      audio_sample_word,
  input  logic             audio_valid,
  output logic             audio_ready,
  output logic [23:0]      header,
  output logic [3:0][55:0] sub,
  output logic [7:0]       frame_count
);

  localparam logic [7:0]  Vic8      = 8'(VIC);
  localparam logic [7:0]  AviSum    = 8'(8'h82 + 8'h02 + 8'h0D + 8'h10 + 8'h08 + Vic8);
  localparam logic [7:0]  AviPb0    = 8'(8'h00 - AviSum);
  localparam logic [23:0] AviHeader = 24'h0D0282;
  localparam logic [55:0] AviSub0   = {16'h0000, Vic8, 8'h00, 8'h08, 8'h10, AviPb0};

  localparam logic [19:0] AcrN   = 20'(AUDIO_N);
  localparam logic [19:0] AcrCts = 20'(AUDIO_CTS);
  localparam logic [55:0] AcrSub = {AcrN[7:0], AcrN[15:8], 4'h0, AcrN[19:16],
                                    AcrCts[7:0], AcrCts[15:8], 4'h0, AcrCts[19:16], 8'h00};

  logic             avi_pend_q, avi_pend_d;
  logic [23:0]      header_q, header_d;
  logic [3:0][55:0] sub_q, sub_d;
  logic             sel_avi;

`ifdef HDMI_AUDIO_EN
  localparam int unsigned   Aw        = $clog2(AUDIO_FIFO_DEPTH);
  localparam logic [7:0]    AifPb0    = 8'(8'h00 - 8'(8'h84 + 8'h01 + 8'h0A + 8'h01));
  localparam logic [23:0]   AifHeader = 24'h0A0184;
  localparam logic [55:0]   AifSub0   = {40'h0, 8'h01, AifPb0};
  localparam logic [Aw:0]   PtrOne    = (Aw + 1)'(1);

  logic        acr_pend_q, acr_pend_d;
  logic        aif_pend_q, aif_pend_d;
  logic [Aw:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]  frame_count_q, frame_count_d;
  logic [47:0] fifo_mem_q [AUDIO_FIFO_DEPTH];
  logic        fifo_empty, fifo_full, push, pop, sel_acr, sel_aif, par_l, par_r;
  logic [47:0] smp;

  // Extra pointer MSB distinguishes full from empty.
  assign fifo_empty  = (wptr_q == rptr_q);
  assign fifo_full   = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign audio_ready = ~fifo_full;
  assign push        = audio_valid & ~fifo_full;

  // Pop decision uses pre-push occupancy, so a same-cycle push is never eligible.
  assign sel_acr = packet_enable & acr_pend_q;
  assign pop     = packet_enable & ~acr_pend_q & ~fifo_empty;
  assign sel_avi = packet_enable & ~acr_pend_q & fifo_empty & avi_pend_q;
  assign sel_aif = packet_enable & ~acr_pend_q & fifo_empty & ~avi_pend_q & aif_pend_q;

  assign smp         = fifo_mem_q[rptr_q[Aw-1:0]];
  assign par_l       = ^smp[23:0];
  assign par_r       = ^smp[47:24];
  assign frame_count = frame_count_q;

  always_comb begin
    acr_pend_d    = (acr_pend_q & ~sel_acr) | acr_tick;
    aif_pend_d    = (aif_pend_q & ~sel_aif) | video_field_end;
    wptr_d        = push ? wptr_q + PtrOne : wptr_q;
    rptr_d        = pop ? rptr_q + PtrOne : rptr_q;
    frame_count_d = frame_count_q;
    if (pop) begin
      frame_count_d = (frame_count_q == 8'd191) ? 8'd0 : frame_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      acr_pend_q    <= 1'b0;
      aif_pend_q    <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      frame_count_q <= 8'd0;
    end else begin
      acr_pend_q    <= acr_pend_d;
      aif_pend_q    <= aif_pend_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (push && !reset) begin
      fifo_mem_q[wptr_q[Aw-1:0]] <= audio_sample_word;
    end
  end
`else
  logic unused_audio;

  assign sel_avi      = packet_enable & avi_pend_q;
  assign audio_ready  = 1'b1;
  assign frame_count  = 8'd0;
  assign unused_audio = ^{acr_tick, audio_sample_word, audio_valid, AcrSub,
                          32'(AUDIO_FIFO_DEPTH)};
`endif

  assign header = header_q;
  assign sub    = sub_q;

  // Select signals are mutually exclusive, so the independent ifs encode the priority.
  always_comb begin
    avi_pend_d = (avi_pend_q & ~sel_avi) | video_field_end;
    header_d   = header_q;
    sub_d      = sub_q;
    if (packet_enable) begin
      header_d = '0;
      sub_d    = '0;
`ifdef HDMI_AUDIO_EN
      if (sel_acr) begin
        header_d = 24'h000001;
        sub_d    = {4{AcrSub}};
      end
      if (pop) begin
        header_d = {3'b000, frame_count_q == 8'd0, 4'h0, 8'h01, 8'h02};
        sub_d[0] = {par_r, 3'b000, par_l, 3'b000, smp};
      end
      if (sel_aif) begin
        header_d = AifHeader;
        sub_d[0] = AifSub0;
      end
`endif
      if (sel_avi) begin
        header_d = AviHeader;
        sub_d[0] = AviSub0;
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      avi_pend_q <= 1'b0;
      header_q   <= '0;
      sub_q      <= '0;
    end else begin
      avi_pend_q <= avi_pend_d;
      header_q   <= header_d;
      sub_q      <= sub_d;
    end
  end

endmodule

// File: tb/tb_hdmi_packet_picker.sv
// Directed-vector bench for hdmi_packet_picker; the audio sections build only with HDMI_AUDIO_EN.
module tb_hdmi_packet_picker;

  localparam logic [23:0] AVI_H = 24'h0D0282;
  localparam logic [55:0] AVI_S = 56'h00000100081056;
  localparam logic [23:0] AIF_H = 24'h0A0184;
  localparam logic [55:0] AIF_S = 56'h00000000000170;
  localparam logic [55:0] ACR_S = 56'h00180078690000;

  typedef struct {
    logic         pe, vfe, acr, valid;
    logic [47:0]  word;
    logic [23:0]  eh;
    logic [223:0] es;
    logic         er;
    logic [7:0]   ef;
  } vec_t;

  logic clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  logic             reset, packet_enable, video_field_end, acr_tick, audio_valid, audio_ready;
  logic [47:0]      audio_sample_word;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic [7:0]       frame_count;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  fc_exp = 8'd0;
  vec_t        vecs[$];
  logic [47:0] w [5];
  logic [55:0] s [4];

  hdmi_packet_picker dut (
    .clk_pixel         (clk_pixel),
    .reset             (reset),
    .packet_enable     (packet_enable),
    .video_field_end   (video_field_end),
    .acr_tick          (acr_tick),
    .audio_sample_word (audio_sample_word),
    .audio_valid       (audio_valid),
    .audio_ready       (audio_ready),
    .header            (header),
    .sub               (sub),
    .frame_count       (frame_count)
  );

  task automatic step(input logic pe, input logic vfe, input logic acr, input logic valid,
                      input logic [47:0] word);
    packet_enable     = pe;
    video_field_end   = vfe;
    acr_tick          = acr;
    audio_valid       = valid;
    audio_sample_word = word;
    @(posedge clk_pixel);
    #1;
    packet_enable   = 1'b0;
    video_field_end = 1'b0;
    acr_tick        = 1'b0;
    audio_valid     = 1'b0;
  endtask

  task automatic check(input string name, input logic [23:0] eh, input logic [223:0] es,
                       input logic er, input logic [7:0] ef);
    n_vec++;
    if (header !== eh || sub !== es || audio_ready !== er || frame_count !== ef) begin
      n_err++;
      $display("FAIL %s: got header=%h sub=%h ready=%b fc=%0d, want header=%h sub=%h ready=%b fc=%0d",
               name, header, sub, audio_ready, frame_count, eh, es, er, ef);
    end
  endtask

  function automatic void add(input logic pe, input logic vfe, input logic acr,
                              input logic valid, input logic [23:0] eh, input logic [55:0] es0);
    vecs.push_back('{pe, vfe, acr, valid, 48'h123456_654321, eh, {168'h0, es0}, 1'b1, 8'd0});
  endfunction

  initial begin
    reset             = 1'b1;
    packet_enable     = 1'b0;
    video_field_end   = 1'b0;
    acr_tick          = 1'b0;
    audio_valid       = 1'b0;
    audio_sample_word = '0;
    repeat (2) @(posedge clk_pixel);
    #1 reset = 1'b0;
    check("reset_state", 24'h0, '0, 1'b1, 8'd0);

    // pe, vfe, acr, valid, header, sub[0]
    add(0, 0, 0, 0, 24'h0, 56'h0);
    add(1, 0, 0, 0, 24'h0, 56'h0);
    add(0, 1, 0, 0, 24'h0, 56'h0);
    add(1, 0, 0, 0, AVI_H, AVI_S);
    add(0, 0, 0, 0, AVI_H, AVI_S);
`ifdef HDMI_AUDIO_EN
    add(1, 0, 0, 0, AIF_H, AIF_S);
    add(1, 0, 0, 0, 24'h0, 56'h0);
    add(1, 1, 0, 0, 24'h0, 56'h0);
    add(1, 0, 0, 0, AVI_H, AVI_S);
    add(1, 1, 0, 0, AIF_H, AIF_S);
    add(1, 0, 0, 0, AVI_H, AVI_S);
    add(1, 0, 0, 0, AIF_H, AIF_S);
    add(1, 0, 0, 0, 24'h0, 56'h0);
`else
    add(1, 0, 0, 0, 24'h0, 56'h0);
    add(1, 1, 0, 0, 24'h0, 56'h0);
    add(1, 0, 0, 0, AVI_H, AVI_S);
    add(0, 1, 0, 0, AVI_H, AVI_S);
    add(1, 1, 0, 0, AVI_H, AVI_S);
    add(1, 0, 0, 0, AVI_H, AVI_S);
    add(1, 0, 0, 0, 24'h0, 56'h0);
    add(0, 0, 1, 1, 24'h0, 56'h0);
    add(1, 0, 1, 1, 24'h0, 56'h0);
    add(1, 0, 0, 0, 24'h0, 56'h0);
`endif
    foreach (vecs[i]) begin
      step(vecs[i].pe, vecs[i].vfe, vecs[i].acr, vecs[i].valid, vecs[i].word);
      check($sformatf("vec%0d", i), vecs[i].eh, vecs[i].es, vecs[i].er, vecs[i].ef);
    end

`ifdef HDMI_AUDIO_EN
    w[0] = {24'h000003, 24'h000001};  s[0] = 56'h08000003000001;
    w[1] = {24'h800000, 24'hFFFFFF};  s[1] = 56'h80800000FFFFFF;
    w[2] = {24'hABCDEF, 24'h123456};  s[2] = 56'h88ABCDEF123456;
    w[3] = {24'h0000F0, 24'h700000};  s[3] = 56'h080000F0700000;
    w[4] = 48'hDEAD_BEEF_0000;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, w[i]);
      check($sformatf("push%0d", i), 24'h0, '0, i < 3, 8'd0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      check($sformatf("sample%0d", i), (i == 0) ? 24'h100102 : 24'h000102, {168'h0, s[i]},
            1'b1, 8'(i + 1));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("fifo_drained", 24'h0, '0, 1'b1, 8'd4);

    step(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("acr_vfe_hold", 24'h0, '0, 1'b1, 8'd4);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("acr_first", 24'h000001, {4{ACR_S}}, 1'b1, 8'd4);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("avi_after_acr", AVI_H, {168'h0, AVI_S}, 1'b1, 8'd4);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("aif_after_avi", AIF_H, {168'h0, AIF_S}, 1'b1, 8'd4);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("null_after_aif", 24'h0, '0, 1'b1, 8'd4);
    fc_exp = 8'd4;
`endif

    // Reset mid-slot with pending InfoFrames and a buffered sample.
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("pre_reset_avi", AVI_H, {168'h0, AVI_S}, 1'b1, fc_exp);
    step(1'b0, 1'b1, 1'b0, 1'b1, 48'h111111_222222);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 48'h333333_444444);
    check("reset_mid_slot", 24'h0, '0, 1'b1, 8'd0);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("post_reset_slot0", 24'h0, '0, 1'b1, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("post_reset_slot1", 24'h0, '0, 1'b1, 8'd0);

`ifdef HDMI_AUDIO_EN
    // Push each slot alongside packet_enable: first slot sees no bypass, then 193 sample packets.
    for (int i = 0; i <= 193; i++) begin
      step(1'b1, 1'b0, 1'b0, i < 193, '0);
      if (i == 0) check("no_bypass", 24'h0, '0, 1'b1, 8'd0);
      else check($sformatf("frame%0d", i - 1), ((i - 1) % 192 == 0) ? 24'h100102 : 24'h000102,
                 '0, 1'b1, 8'(i % 192));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
